mips_instr_encoder: RTL

Sequential instruction encoder and program loader, the inverse of the main control decoder: accepts symbolic instructions (mnemonic code plus register/immediate fields) over a valid/ready handshake, packs them into 32-bit MIPS machine words, and writes them sequentially into instruction memory. It sits between the testbench/boot host and the instruction-memory write port, so directed programs can be loaded without hand-assembled hex files.

---
 rtl/mips_isa_pkg.sv | 77 +++++++
 rtl/mips_instr_pack.sv | 73 +++++++
 rtl/mips_instr_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic codes, opcode/funct constants, error codes and word-packing helpers.
// The extended-branch opcodes are only used when ENC_EXT_BRANCH_EN is defined.
package mips_isa_pkg;

  typedef enum logic [5:0] {
    MN_ADD, MN_SUB, MN_AND, MN_OR, MN_SLT, MN_JR, MN_JALR,
    MN_MULT, MN_DIV, MN_MULTU, MN_DIVU, MN_MFHI, MN_MFLO, MN_MTHI, MN_MTLO,
    MN_LW, MN_SW, MN_LB, MN_LH, MN_LBU, MN_LHU, MN_SB, MN_SH,
    MN_BEQ, MN_BNE, MN_ADDI, MN_ADDIU, MN_ANDI, MN_ORI, MN_XORI, MN_SLTI, MN_SLTIU,
    MN_LUI, MN_BLEZ, MN_BGTZ, MN_BLTZ, MN_BGEZ, MN_J, MN_JAL,
    MN_BLT, MN_BGE, MN_BLE, MN_BGT
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BLT   = 6'b111001;
  localparam logic [5:0] OP_BGE   = 6'b111010;
  localparam logic [5:0] OP_BLE   = 6'b111011;
  localparam logic [5:0] OP_BGT   = 6'b111100;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNSUP = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: mnemonic plus register/immediate fields into a 32-bit MIPS word.
// Define ENC_EXT_BRANCH_EN to accept the custom BLT/BGE/BLE/BGT two-register branches.
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        supported
);

  logic [15:0] imm16;
  assign imm16 = imm[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    word      = '0;
    supported = 1'b1;
    case (mnem)
      MN_ADD:   word = r_word(rs, rt, rd, FN_ADD);
      MN_SUB:   word = r_word(rs, rt, rd, FN_SUB);
      MN_AND:   word = r_word(rs, rt, rd, FN_AND);
      MN_OR:    word = r_word(rs, rt, rd, FN_OR);
      MN_SLT:   word = r_word(rs, rt, rd, FN_SLT);
      MN_JR:    word = r_word(rs, 5'd0, 5'd0, FN_JR);
      MN_JALR:  word = r_word(rs, rt, rd, FN_JALR);
      MN_MULT:  word = r_word(rs, rt, 5'd0, FN_MULT);
      MN_DIV:   word = r_word(rs, rt, 5'd0, FN_DIV);
      MN_MULTU: word = r_word(rs, rt, 5'd0, FN_MULTU);
      MN_DIVU:  word = r_word(rs, rt, 5'd0, FN_DIVU);
      MN_MFHI:  word = r_word(5'd0, 5'd0, rd, FN_MFHI);
      MN_MFLO:  word = r_word(5'd0, 5'd0, rd, FN_MFLO);
      MN_MTHI:  word = r_word(rs, 5'd0, 5'd0, FN_MTHI);
      MN_MTLO:  word = r_word(rs, 5'd0, 5'd0, FN_MTLO);
      MN_LW:    word = i_word(OP_LW, rs, rt, imm16);
      MN_SW:    word = i_word(OP_SW, rs, rt, imm16);
      MN_LB:    word = i_word(OP_LB, rs, rt, imm16);
      MN_LH:    word = i_word(OP_LH, rs, rt, imm16);
      MN_LBU:   word = i_word(OP_LBU, rs, rt, imm16);
      MN_LHU:   word = i_word(OP_LHU, rs, rt, imm16);
      MN_SB:    word = i_word(OP_SB, rs, rt, imm16);
      MN_SH:    word = i_word(OP_SH, rs, rt, imm16);
      MN_BEQ:   word = i_word(OP_BEQ, rs, rt, imm16);
      MN_BNE:   word = i_word(OP_BNE, rs, rt, imm16);
      MN_ADDI:  word = i_word(OP_ADDI, rs, rt, imm16);
      MN_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm16);
      MN_ANDI:  word = i_word(OP_ANDI, rs, rt, imm16);
      MN_ORI:   word = i_word(OP_ORI, rs, rt, imm16);
      MN_XORI:  word = i_word(OP_XORI, rs, rt, imm16);
      MN_SLTI:  word = i_word(OP_SLTI, rs, rt, imm16);
      MN_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm16);
      MN_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm16);
      MN_BLEZ:  word = i_word(OP_BLEZ, rs, 5'd0, imm16);
      MN_BGTZ:  word = i_word(OP_BGTZ, rs, 5'd0, imm16);
      // BLTZ and BGEZ share the REGIMM opcode; rt selects the condition.
      MN_BLTZ:  word = i_word(OP_REGIMM, rs, 5'd0, imm16);
      MN_BGEZ:  word = i_word(OP_REGIMM, rs, 5'd1, imm16);
      MN_J:     word = j_word(OP_J, imm);
      MN_JAL:   word = j_word(OP_JAL, imm);
`ifdef ENC_EXT_BRANCH_EN
      MN_BLT:   word = i_word(OP_BLT, rs, rt, imm16);
      MN_BGE:   word = i_word(OP_BGE, rs, rt, imm16);
      MN_BLE:   word = i_word(OP_BLE, rs, rt, imm16);
      MN_BGT:   word = i_word(OP_BGT, rs, rt, imm16);
`endif
      default:  supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instructions over valid/ready and writes packed words to instruction memory.
// Extended branches are encoded only when ENC_EXT_BRANCH_EN is defined (see mips_instr_pack).
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0] pack_word;
  logic        pack_ok;
  logic        accept;

  mips_instr_pack u_pack (
    .mnem      (in_mnem),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .imm       (in_imm),
    .word      (pack_word),
    .supported (pack_ok)
  );

  assign in_ready = (state_q == ST_LOAD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (!pack_ok) begin
            state_d    = ST_ERR;
            err_code_d = ERR_UNSUP;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = pack_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W + 1)'(1);
            if (in_last) begin
              state_d = ST_DONE;
            end else if (ptr_q == PTR_MAX) begin
              state_d    = ST_ERR;
              err_code_d = ERR_OVF;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = ST_LOAD;
          ptr_d      = BASE;
          count_d    = '0;
          err_code_d = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= BASE;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

  // Reset masks the strobe immediately so a write registered just before rst never reaches memory.
  assign imem_we    = we_q & ~rst;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign err_code   = err_code_q;
  assign count      = count_q;

endmodule
